fractional_divide: RTL and testbench

- Iterative fixed-point divider that undoes a constant fractional scale.
- Input: an integer+fraction word (OUT_BIT integer, FRAC_BIT fraction), the format produced by the team's constant fractional multiplier.
- Output: an IN_BIT unsigned integer equal to din / FACTOR, rounded half-up and saturated.
- Placement: downstream of the multiplier, wherever a scaled quantity must be mapped back to its original units. Restoring radix-2 division, one quotient bit per clock, valid/ready on both sides.

---
 rtl/fractional_divide.sv | 168 ++++++++++++++++
 tb/tb_fractional_divide.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fractional_divide.sv
// fractional_divide
// -----------------
// Iterative restoring divider that maps a scaled fixed-point word back to the
// original integer units: dout = round_half_up({din_int,din_frac} / FACTOR),
// saturated to IN_BIT bits. One quotient bit per clock, MSB first.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active high
//   in_valid   dividend word valid       (input handshake)
//   in_ready   block idle, word accepted when in_valid && in_ready
//   din_int    integer part of dividend  (OUT_BIT bits)
//   din_frac   fraction part of dividend (FRAC_BIT bits)
//   out_valid  result valid, held until out_ready
//   out_ready  sink accepts result
//   dout       rounded, saturated quotient (IN_BIT bits)
//   sat        dout was clipped to 2^IN_BIT-1
module fractional_divide #(
  parameter real FACTOR   = 0.5,
  parameter int  IN_BIT   = 8,
  parameter int  OUT_BIT  = 6,
  parameter int  FRAC_BIT = 8,
  parameter int  Q_BITS   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OUT_BIT-1:0]  din_int,
  input  logic [FRAC_BIT-1:0] din_frac,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [IN_BIT-1:0]   dout,
  output logic                sat
);

  // Numerator/quotient width; also the number of division steps.
  localparam int NW    = OUT_BIT + Q_BITS + 1;
  // Aligns the dividend with the Q_BITS divisor and adds one extra bit of
  // quotient precision that the half-up rounding consumes.
  localparam int SHIFT = Q_BITS - FRAC_BIT + 1;
  localparam int CW    = $clog2(NW);

  // Divisor quantised by truncation ($rtoi truncates toward zero).
  localparam longint            FQ_FULL     = longint'($rtoi(FACTOR * (2.0 ** Q_BITS)));
  localparam logic [Q_BITS-1:0] FACTOR_QUAN = FQ_FULL[Q_BITS-1:0];

  if (Q_BITS < FRAC_BIT) begin : g_chk_qbits
    $error("fractional_divide: Q_BITS must be >= FRAC_BIT");
  end
  if (FACTOR_QUAN == 0) begin : g_chk_factor
    $error("fractional_divide: FACTOR quantises to zero");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIV   = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [NW-1:0]       n_q, n_d;        // dividend, shifted out MSB first
  logic [Q_BITS:0]     rem_q, rem_d;    // partial remainder, always < FACTOR_QUAN
  logic [NW-1:0]       quot_q, quot_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IN_BIT-1:0]   dout_q, dout_d;
  logic                sat_q, sat_d;
  logic                out_valid_q, out_valid_d;

  // Datapath helpers
  logic [Q_BITS+1:0]   rem_shift;
  logic                take;
  logic [Q_BITS:0]     rem_sub;
  logic [NW:0]         q_inc;
  logic [NW-1:0]       r;
  logic                over;

  always_comb begin
    // Remainder shifted left with the next dividend bit. The extra top bit
    // keeps the compare exact even though it is always zero in practice.
    rem_shift = {rem_q, n_q[NW-1]};
    take      = rem_shift >= {2'b00, FACTOR_QUAN};
    rem_sub   = rem_shift[Q_BITS:0] - {1'b0, FACTOR_QUAN};
    // The quotient carries one extra fractional bit; (q+1)>>1 rounds half-up.
    q_inc     = {1'b0, quot_q} + {{NW{1'b0}}, 1'b1};
    r         = NW'(q_inc >> 1);
  end

  if (NW > IN_BIT) begin : g_sat
    assign over = |r[NW-1:IN_BIT];
  end else begin : g_nosat
    assign over = 1'b0;
  end

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    rem_d       = rem_q;
    quot_d      = quot_q;
    cnt_d       = cnt_q;
    dout_d      = dout_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          n_d     = NW'({din_int, din_frac}) << SHIFT;
          rem_d   = '0;
          quot_d  = '0;
          cnt_d   = CW'(NW - 1);
          state_d = DIV;
        end
      end
      DIV: begin
        n_d    = n_q << 1;
        rem_d  = take ? rem_sub : rem_shift[Q_BITS:0];
        quot_d = {quot_q[NW-2:0], take};
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        dout_d      = over ? {IN_BIT{1'b1}} : IN_BIT'(r);
        sat_d       = over;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      n_q         <= '0;
      rem_q       <= '0;
      quot_q      <= '0;
      cnt_q       <= '0;
      dout_q      <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      rem_q       <= rem_d;
      quot_q      <= quot_d;
      cnt_q       <= cnt_d;
      dout_q      <= dout_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_fractional_divide.sv
// Testbench for fractional_divide. Four instances with different FACTOR /
// Q_BITS share clock and reset. A negedge monitor keeps a one-slot
// behavioural model per instance and checks handshake, latency and results
// every cycle; directed transactions pin literal expectations.
module tb_fractional_divide;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid  [4];
  logic       in_ready  [4];
  logic       out_valid [4];
  logic       out_ready [4];
  logic       sat       [4];
  logic [5:0] din_int   [4];
  logic [7:0] din_frac  [4];
  logic [7:0] dout      [4];

  always #5 clk = ~clk;

  fractional_divide #(.FACTOR(0.5),  .Q_BITS(16)) u0 (.clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .din_int(din_int[0]), .din_frac(din_frac[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]), .dout(dout[0]), .sat(sat[0]));
  fractional_divide #(.FACTOR(0.25), .Q_BITS(16)) u1 (.clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .din_int(din_int[1]), .din_frac(din_frac[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]), .dout(dout[1]), .sat(sat[1]));
  fractional_divide #(.FACTOR(0.3),  .Q_BITS(8))  u2 (.clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .din_int(din_int[2]), .din_frac(din_frac[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]), .dout(dout[2]), .sat(sat[2]));
  fractional_divide #(.FACTOR(0.75), .Q_BITS(16)) u3 (.clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
    .din_int(din_int[3]), .din_frac(din_frac[3]), .out_valid(out_valid[3]), .out_ready(out_ready[3]), .dout(dout[3]), .sat(sat[3]));

  int     n_checks = 0;
  int     n_pass   = 0;
  longint cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input int k, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s inst%0d: got %0d, expected %0d (t=%0t)", name, k, act, exp, $time);
  endfunction

  function automatic int qb_of(input int k);
    return (k == 2) ? 8 : 16;
  endfunction

  function automatic real factor_of(input int k);
    case (k)
      0:       return 0.5;
      1:       return 0.25;
      2:       return 0.3;
      default: return 0.75;
    endcase
  endfunction

  // Reference: {sat, dout} from plain integer arithmetic.
  function automatic logic [8:0] model(input int k, input int unsigned di, input int unsigned df);
    longint fq, n, q, r;
    int qb;
    qb = qb_of(k);
    fq = longint'($rtoi(factor_of(k) * (2.0 ** qb))) % (longint'(1) << qb);
    n  = ((longint'(di) * 256) + longint'(df)) * (longint'(1) << (qb - 8 + 1));
    q  = n / fq;
    r  = (q + 1) / 2;
    if (r > 255) return {1'b1, 8'd255};
    return {1'b0, r[7:0]};
  endfunction

  // One-slot model state per instance
  bit         pending [4];
  bit         seen    [4];
  logic [8:0] expv    [4];
  longint     acc_cyc [4];
  int         acc_cnt [4];
  int         del_cnt [4];
  int         drop_cnt[4];
  int         cur_di  [4];
  int         cur_df  [4];

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (rst) begin
        check("rst_in_ready", k, in_ready[k], 1);
        check("rst_out_valid", k, out_valid[k], 0);
        check("rst_dout", k, dout[k], 0);
        check("rst_sat", k, sat[k], 0);
        if (pending[k]) drop_cnt[k]++;
        pending[k] = 1'b0;
        seen[k]    = 1'b0;
      end else begin
        bit acc;
        acc = in_valid[k] && !pending[k];
        check("in_ready", k, in_ready[k], !pending[k]);
        if (!pending[k]) begin
          check("idle_out_valid", k, out_valid[k], 0);
        end else if (out_valid[k]) begin
          if (!seen[k]) begin
            check("latency", k, cyc - acc_cyc[k], 6 + qb_of(k) + 1 + 1);
            seen[k] = 1'b1;
          end
          check("dout", k, dout[k], expv[k][7:0]);
          check("sat", k, sat[k], expv[k][8]);
          if (out_ready[k]) begin
            $display("txn inst%0d din=%0d+%0d/256 dout=%0d sat=%0d", k, cur_di[k], cur_df[k], dout[k], sat[k]);
            pending[k] = 1'b0;
            seen[k]    = 1'b0;
            del_cnt[k]++;
          end
        end
        if (acc) begin
          pending[k] = 1'b1;
          expv[k]    = model(k, din_int[k], din_frac[k]);
          acc_cyc[k] = cyc + 1;
          cur_di[k]  = din_int[k];
          cur_df[k]  = din_frac[k];
          acc_cnt[k]++;
        end
      end
    end
  end

  task automatic run_txn(input int k, input int di, input int df, input int exp_d, input int exp_s, input int hold);
    int t;
    @(posedge clk); #1;
    din_int[k] = 6'(di); din_frac[k] = 8'(df); in_valid[k] = 1'b1; out_ready[k] = 1'b0;
    t = 0;
    while (!in_ready[k] && t < 100) begin @(posedge clk); #1; t++; end
    @(posedge clk); #1;  // acceptance edge
    // During backpressure keep a different word offered; it must be ignored.
    in_valid[k] = (hold > 0);
    din_int[k]  = 6'(di + 7);
    t = 0;
    while (!out_valid[k] && t < 100) begin @(posedge clk); #1; t++; end
    check("dir_valid", k, out_valid[k], 1);
    check("dir_dout", k, dout[k], exp_d);
    check("dir_sat", k, sat[k], exp_s);
    repeat (hold) @(posedge clk);
    #1;
    check("hold_valid", k, out_valid[k], 1);
    check("hold_dout", k, dout[k], exp_d);
    check("hold_in_ready", k, in_ready[k], 0);
    in_valid[k] = 1'b0; out_ready[k] = 1'b1;
    @(posedge clk); #1;
    out_ready[k] = 1'b0;
    check("post_in_ready", k, in_ready[k], 1);
    check("post_out_valid", k, out_valid[k], 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int budget;
    int base;
    int total;
    for (int k = 0; k < 4; k++) begin
      in_valid[k] = 1'b0; out_ready[k] = 1'b0; din_int[k] = '0; din_frac[k] = '0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Directed, literal expectations
    run_txn(0, 50, 0, 100, 0, 0);
    run_txn(0, 50, 128, 101, 0, 0);
    run_txn(0, 63, 255, 128, 0, 0);
    run_txn(0, 0, 0, 0, 0, 0);
    run_txn(1, 63, 255, 255, 1, 0);
    run_txn(1, 10, 0, 40, 0, 0);
    run_txn(0, 37, 64, 75, 0, 50);   // backpressure for 50 cycles

    // Reset in the middle of a division
    @(posedge clk); #1;
    din_int[0] = 6'd50; din_frac[0] = 8'd0; in_valid[0] = 1'b1;
    @(posedge clk); #1;              // acceptance edge
    in_valid[0] = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("arst_in_ready", 0, in_ready[0], 1);
    check("arst_out_valid", 0, out_valid[0], 0);
    check("arst_dout", 0, dout[0], 0);
    check("arst_sat", 0, sat[0], 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("no_spurious_valid", 0, out_valid[0], 0);
    run_txn(0, 20, 0, 40, 0, 0);

    // Random back-to-back traffic on all instances
    base = 0;
    for (int k = 0; k < 4; k++) base += acc_cnt[k];
    budget = 0;
    total  = 0;
    while (total < 1000 && budget < 30000) begin
      @(posedge clk); #1;
      for (int k = 0; k < 4; k++) begin
        in_valid[k]  = ($urandom_range(0, 9) < 7);
        out_ready[k] = ($urandom_range(0, 9) < 6);
        case ($urandom_range(0, 15))
          0:       begin din_int[k] = 6'd0;  din_frac[k] = 8'd0;   end
          1:       begin din_int[k] = 6'd63; din_frac[k] = 8'd255; end
          default: begin din_int[k] = 6'($urandom); din_frac[k] = 8'($urandom); end
        endcase
      end
      budget++;
      total = -base;
      for (int k = 0; k < 4; k++) total += acc_cnt[k];
    end
    check("random_budget", -1, budget < 30000, 1);

    // Drain and reconcile transaction counts
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin in_valid[k] = 1'b0; out_ready[k] = 1'b1; end
    repeat (60) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      check("drained", k, pending[k], 0);
      check("txn_count", k, acc_cnt[k], del_cnt[k] + drop_cnt[k]);
    end
    check("dropped_by_reset", 0, drop_cnt[0], 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
